// File: rtl/datapath_pkg.sv
// Shared datapath definitions: PC source encodings, the NOP word and the default reset PC.
package datapath_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_JUMP   = 2'd1,
    PC_REG    = 2'd2,
    PC_BRANCH = 2'd3
  } pcsrc_e;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC computation: PC+4, jump, register and branch targets, 4-way select on PCSrc.
module next_pc_sel
  import datapath_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] redir_pcplus4,
  input  logic [25:0] redir_index,
  input  logic [15:0] redir_imm,
  input  logic [31:0] redir_reg,
  output logic [31:0] next_pc
);

  logic [31:0] seq_tgt, jump_tgt, reg_tgt, branch_tgt;

  assign seq_tgt    = pc + 32'd4;
  assign jump_tgt   = {redir_pcplus4[31:28], redir_index, 2'b00};
  // Low bits are forced to zero; the fetch stage reports the misalignment separately.
  assign reg_tgt    = redir_reg & 32'hFFFF_FFFC;
  assign branch_tgt = redir_pcplus4 + {{14{redir_imm[15]}}, redir_imm, 2'b00};

  always_comb begin
    next_pc = seq_tgt;
    case (pcsrc_e'(pcsrc))
      PC_SEQ:    next_pc = seq_tgt;
      PC_JUMP:   next_pc = jump_tgt;
      PC_REG:    next_pc = reg_tgt;
      PC_BRANCH: next_pc = branch_tgt;
      default:   next_pc = seq_tgt;
    endcase
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID register with stall/flush, misalign flag.
// Optional PC_FETCH_STALL_CNT_EN adds a saturating Stall_Cnt output.
module pc_fetch_stage
  import datapath_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_WORD = datapath_pkg::NOP_WORD
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] Redir_PCPlus4,
  input  logic [25:0] Redir_Index,
  input  logic [15:0] Redir_Imm,
  input  logic [31:0] Redir_Reg,
  input  logic [31:0] IMem_Data,
  output logic [31:0] IMem_Addr,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
`ifdef PC_FETCH_STALL_CNT_EN
  output logic        Misalign,
  output logic [31:0] Stall_Cnt
`else
  output logic        Misalign
`endif
);

  logic [31:0] pc, pc_plus4, redir_pc;

  assign pc_plus4  = pc + 32'd4;
  assign IMem_Addr = pc;

  next_pc_sel u_sel (
    .pc            (pc),
    .pcsrc         (PCSrc),
    .redir_pcplus4 (Redir_PCPlus4),
    .redir_index   (Redir_Index),
    .redir_imm     (Redir_Imm),
    .redir_reg     (Redir_Reg),
    .next_pc       (redir_pc)
  );

  // Redirect outranks Stall: the target is loaded and the wrong-path word in IF/ID is squashed.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc           <= RESET_PC;
      IFID_Instr   <= NOP_WORD;
      IFID_PCPlus4 <= 32'd0;
      IFID_Valid   <= 1'b0;
      Misalign     <= 1'b0;
    end else if (Redirect) begin
      pc           <= redir_pc;
      IFID_Instr   <= NOP_WORD;
      IFID_PCPlus4 <= 32'd0;
      IFID_Valid   <= 1'b0;
      Misalign     <= (PCSrc == PC_REG) && (Redir_Reg[1:0] != 2'b00);
    end else if (Stall) begin
      Misalign     <= 1'b0;
    end else begin
      pc           <= pc_plus4;
      IFID_Instr   <= IMem_Data;
      IFID_PCPlus4 <= pc_plus4;
      IFID_Valid   <= 1'b1;
      Misalign     <= 1'b0;
    end
  end

`ifdef PC_FETCH_STALL_CNT_EN
  always_ff @(posedge Clk) begin
    if (Rst)
      Stall_Cnt <= 32'd0;
    else if (Stall && !Redirect && (Stall_Cnt != 32'hFFFF_FFFF))
      Stall_Cnt <= Stall_Cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: cycle-level model plus directed literal checks.
module tb_pc_fetch_stage;

  logic        Clk = 1'b0;
  logic        Rst, Stall, Redirect;
  logic [1:0]  PCSrc;
  logic [31:0] Redir_PCPlus4, Redir_Reg, IMem_Data;
  logic [25:0] Redir_Index;
  logic [15:0] Redir_Imm;
  logic [31:0] IMem_Addr, IFID_Instr, IFID_PCPlus4;
  logic        IFID_Valid, Misalign;
`ifdef PC_FETCH_STALL_CNT_EN
  logic [31:0] Stall_Cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 Clk = ~Clk;

  pc_fetch_stage dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Redirect(Redirect), .PCSrc(PCSrc),
    .Redir_PCPlus4(Redir_PCPlus4), .Redir_Index(Redir_Index), .Redir_Imm(Redir_Imm),
    .Redir_Reg(Redir_Reg), .IMem_Data(IMem_Data), .IMem_Addr(IMem_Addr),
    .IFID_Instr(IFID_Instr), .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid),
`ifdef PC_FETCH_STALL_CNT_EN
    .Misalign(Misalign), .Stall_Cnt(Stall_Cnt)
`else
    .Misalign(Misalign)
`endif
  );

  // Instruction memory contents used by both DUT and model.
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h2001_0005;
      32'h4:   return 32'h2002_0007;
      32'h8:   return 32'h0022_1820;
      default: return 32'hAC00_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  always_comb IMem_Data = imem(IMem_Addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: what each output must be after each edge.
  logic [31:0] m_pc, m_instr, m_p4, m_cnt;
  logic        m_valid, m_mis;
  bit          m_ok = 0;

  always @(posedge Clk) begin
    logic [31:0] tgt;
    if (Rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_p4 = 32'h0; m_valid = 0; m_mis = 0; m_cnt = 0; m_ok = 1;
    end else if (Redirect) begin
      case (PCSrc)
        2'd0: tgt = m_pc + 32'd4;
        2'd1: tgt = (Redir_PCPlus4 & 32'hF000_0000) + 32'(Redir_Index) * 32'd4;
        2'd2: tgt = (Redir_Reg / 32'd4) * 32'd4;
        default: tgt = Redir_PCPlus4 + 32'($signed(Redir_Imm)) * 32'd4;
      endcase
      m_mis   = (PCSrc == 2'd2) && (Redir_Reg % 32'd4 != 0);
      m_pc    = tgt;
      m_instr = 32'h0; m_p4 = 32'h0; m_valid = 0;
    end else if (Stall) begin
      m_mis = 0;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else begin
      m_instr = imem(m_pc);
      m_p4    = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_valid = 1;
      m_mis   = 0;
    end
  end

  always @(negedge Clk) begin
    if (m_ok) begin
      check("cyc_addr",  IMem_Addr,         m_pc);
      check("cyc_instr", IFID_Instr,        m_instr);
      check("cyc_p4",    IFID_PCPlus4,      m_p4);
      check("cyc_valid", {31'h0, IFID_Valid}, {31'h0, m_valid});
      check("cyc_mis",   {31'h0, Misalign},   {31'h0, m_mis});
`ifdef PC_FETCH_STALL_CNT_EN
      check("cyc_cnt",   Stall_Cnt,         m_cnt);
`endif
    end
  end

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
    #1;
  endtask

  task automatic redir(input logic [1:0] src, input logic [31:0] p4, input logic [25:0] idx,
                       input logic [15:0] imm, input logic [31:0] r);
    Redirect = 1; PCSrc = src; Redir_PCPlus4 = p4; Redir_Index = idx; Redir_Imm = imm; Redir_Reg = r;
  endtask

  initial begin
    Rst = 1; Stall = 0; Redirect = 0; PCSrc = 0;
    Redir_PCPlus4 = 0; Redir_Index = 0; Redir_Imm = 0; Redir_Reg = 0;
    tick();
    check("rst_addr", IMem_Addr, 32'h0);
    check("rst_valid", {31'h0, IFID_Valid}, 32'h0);
    check("rst_instr", IFID_Instr, 32'h0);
    Rst = 0;

    tick();
    check("seq1_addr", IMem_Addr, 32'h4);
    check("seq1_instr", IFID_Instr, 32'h2001_0005);
    check("seq1_valid", {31'h0, IFID_Valid}, 32'h1);
    tick();
    check("seq2_addr", IMem_Addr, 32'h8);
    check("seq2_p4", IFID_PCPlus4, 32'h8);

    Stall = 1;
    tick(); tick();
    check("stall_addr", IMem_Addr, 32'h8);
    check("stall_instr", IFID_Instr, 32'h2002_0007);
    Stall = 0;
    tick();
    check("rel_addr", IMem_Addr, 32'hC);
    check("rel_instr", IFID_Instr, 32'h0022_1820);
    check("rel_p4", IFID_PCPlus4, 32'hC);

    redir(2'd1, 32'h0040_0010, 26'h100, 16'h0, 32'h0);
    tick();
    check("jmp_addr", IMem_Addr, 32'h0000_0400);
    check("jmp_valid", {31'h0, IFID_Valid}, 32'h0);
    check("jmp_instr", IFID_Instr, 32'h0);
    Redirect = 0;
    tick();
    check("jmp_next", IMem_Addr, 32'h404);

    redir(2'd3, 32'h20, 26'h0, 16'hFFFE, 32'h0);
    tick();
    check("br_addr", IMem_Addr, 32'h18);

    redir(2'd2, 32'h0, 26'h0, 16'h0, 32'h0000_1003);
    tick();
    check("reg_addr", IMem_Addr, 32'h1000);
    check("reg_mis", {31'h0, Misalign}, 32'h1);
    Redirect = 0;
    tick();
    check("reg_mis_clr", {31'h0, Misalign}, 32'h0);
    check("reg_valid", {31'h0, IFID_Valid}, 32'h1);

    redir(2'd1, 32'h0040_0010, 26'h100, 16'h0, 32'h0);
    Stall = 1;
    tick();
    check("rs_addr", IMem_Addr, 32'h400);
    check("rs_valid", {31'h0, IFID_Valid}, 32'h0);
    Redirect = 0; Stall = 0;
    tick();
    check("rs_refill", IFID_Instr, 32'hAC00_0400);

    redir(2'd2, 32'h0, 26'h0, 16'h0, 32'h0000_1003);
    Stall = 1; Rst = 1;
    tick();
    check("rr_addr", IMem_Addr, 32'h0);
    check("rr_instr", IFID_Instr, 32'h0);
    check("rr_mis", {31'h0, Misalign}, 32'h0);
    Rst = 0; Stall = 0;

    redir(2'd2, 32'h0, 26'h0, 16'h0, 32'hFFFF_FFFC);
    tick();
    check("wrap_pre", IMem_Addr, 32'hFFFF_FFFC);
    Redirect = 0;
    tick();
    check("wrap_addr", IMem_Addr, 32'h0);
    check("wrap_p4", IFID_PCPlus4, 32'h0);

    Stall = 1;
    repeat (5) tick();
    check("cnt_hold", IMem_Addr, 32'h0);
`ifdef PC_FETCH_STALL_CNT_EN
    check("cnt_5", Stall_Cnt, 32'd5);
`endif
    Stall = 0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
